// File: rtl/ifid_skid_reg_pkg.sv
// Shared IF/ID pipeline definitions: control state encoding and the default bubble instruction.
package ifid_skid_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // MIPS sll $0,$0,0
    localparam logic [31:0] NOP_INS_MIPS = 32'h0000_0000;

endpackage

// File: rtl/pipe_skid_entry.sv
// One pipeline holding slot {valid, ins, pc}; clear drops only the valid bit, data is kept.
module pipe_skid_entry #(
    parameter int unsigned INS_W = 32,
    parameter int unsigned PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [INS_W-1:0] d_ins,
    input  logic [PC_W-1:0]  d_pc,
    output logic             valid,
    output logic [INS_W-1:0] ins,
    output logic [PC_W-1:0]  pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ins   <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            ins   <= d_ins;
            pc    <= d_pc;
        end
    end

endmodule

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with 2-entry skid buffer, redirect flush and saturating stall counter.
module ifid_skid_reg
    import ifid_skid_reg_pkg::*;
#(
    parameter int unsigned      INS_W   = 32,
    parameter int unsigned      PC_W    = 32,
    parameter logic [INS_W-1:0] NOP_INS = INS_W'(NOP_INS_MIPS),
    parameter int unsigned      CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INS_W-1:0] in_ins,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INS_W-1:0] out_ins,
    output logic [PC_W-1:0]  out_pc,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t state, state_nxt;

    logic             push, pop;
    logic             main_load, main_clr, skid_load, skid_clr;
    logic             main_valid, skid_valid;
    logic [INS_W-1:0] main_ins, skid_ins, main_d_ins;
    logic [PC_W-1:0]  main_pc, skid_pc, main_d_pc;

    assign push = in_valid & in_ready;
    assign pop  = main_valid & out_ready;

    // Main refills from the skid slot when it holds the next-older instruction.
    assign main_d_ins = skid_valid ? skid_ins : in_ins;
    assign main_d_pc  = skid_valid ? skid_pc  : in_pc;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_nxt = FULL;
                        skid_load = 1'b1;
                    end else if (push && pop) begin
                        main_load = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                        main_clr  = 1'b1;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nxt = ONE;
                        main_load = 1'b1;
                        skid_clr  = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) in_ready <= 1'b1;
        else     in_ready <= (state_nxt != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    pipe_skid_entry #(.INS_W(INS_W), .PC_W(PC_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .clear (main_clr),
        .load  (main_load),
        .d_ins (main_d_ins),
        .d_pc  (main_d_pc),
        .valid (main_valid),
        .ins   (main_ins),
        .pc    (main_pc)
    );

    pipe_skid_entry #(.INS_W(INS_W), .PC_W(PC_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (skid_clr),
        .load  (skid_load),
        .d_ins (in_ins),
        .d_pc  (in_pc),
        .valid (skid_valid),
        .ins   (skid_ins),
        .pc    (skid_pc)
    );

    assign out_valid = main_valid;
    assign out_ins   = main_valid ? main_ins : NOP_INS;
    assign out_pc    = main_pc;

endmodule

// File: doc/ifid_skid_reg.md
Name: ifid_skid_reg

Overview:
- Parametrised IF/ID pipeline register sitting between the fetch stage (I-cache output) and decode.
- Generalises the cache-hit-gated instruction latch:
  - adds a PC field and a valid/ready handshake in both directions;
  - adds a 2-entry skid buffer so decode back-pressure never drops a fetched instruction;
  - adds a synchronous flush for branch redirect;
  - emits a NOP bubble when empty;
  - keeps a saturating stall-cycle counter for performance debug.

Parameters:
- INS_W, 32, instruction width in bits.
- PC_W, 32, program-counter width in bits.
- NOP_INS, 32'h0000_0000, value driven on out_ins when out_valid=0 (MIPS sll $0,$0,0).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch offers an instruction (driven by the I-cache hit).
- in_ready  output  1  register can accept; registered, not combinational from out_ready.
- in_ins  input  INS_W  fetched instruction.
- in_pc  input  PC_W  PC of the fetched instruction.
- flush  input  1  discard all held and incoming instructions (branch/jump redirect).
- out_valid  output  1  decode-side instruction valid.
- out_ready  input  1  decode accepts this cycle.
- out_ins  output  INS_W  instruction to decode; NOP_INS when out_valid=0.
- out_pc  output  PC_W  PC of out_ins; holds last value when out_valid=0.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Only push and pop change state.
- Storage:
  - main entry {m_ins, m_pc} drives the outputs.
  - skid entry {s_ins, s_pc} holds overflow.
- FSM states:
  - EMPTY: out_valid=0.
  - ONE: main valid.
  - FULL: main and skid valid.
- Transitions (evaluated when flush=0):
  - EMPTY: push -> ONE, main<=in.
  - ONE: push & !pop -> FULL, skid<=in.
  - ONE: push & pop -> ONE, main<=in.
  - ONE: !push & pop -> EMPTY.
  - ONE: otherwise hold.
  - FULL: pop -> ONE, main<=skid. No push is possible because in_ready=0.
  - FULL: otherwise hold.
- Derived outputs:
  - in_ready = (state != FULL), registered from next-state.
  - Latency: an instruction pushed at edge N is visible at out_* after edge N, i.e. 1 cycle.
- Ordering: strict FIFO; the main entry is always the older instruction.
- Flush:
  - Highest priority after rst.
  - Next state is EMPTY and in_ready=1.
  - A push in the same cycle is discarded.
  - A pop in the same cycle is still considered consumed by decode.
  - Stored data registers are not cleared; only the valid state changes.
- Reset (rst=1 at an edge, including mid-operation):
  - state=EMPTY, out_valid=0, in_ready=1, out_ins=NOP_INS, out_pc=0, stall_cnt=0.
  - All in-flight entries are lost.
- stall_cnt:
  - Increments at each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - Unaffected by flush; cleared only by rst.
- out_ins is NOP_INS whenever out_valid=0, including directly after flush.
- No combinational path from in_* or out_ready to any output.

Decomposition:
- Shared pipeline package:
  - state encoding localparams: EMPTY=2'd0, ONE=2'd1, FULL=2'd2;
  - NOP_INS constant.
- One sub-module: pipe_skid_entry, a single {valid, ins, pc} register with load/clear. Instantiated twice (main, skid).
- Control FSM and stall counter stay in ifid_skid_reg.

Test Plan:
- Reset, then idle with in_valid=0 -> out_valid=0, out_ins=32'h0, in_ready=1, stall_cnt=0.
- Streaming: push 0x8C020004@pc 0x100, then 0x00431020@0x104, with out_ready=1 -> each appears one cycle after push, in order; in_ready stays 1.
- Back-pressure: out_ready=0, push A@0x200 then B@0x204 -> state FULL, in_ready=0, out shows A; raise out_ready -> A, then B, then out_valid=0; stall_cnt equals the number of held cycles.
- Flush in FULL with a simultaneous in_valid=1 (C@0x300) -> next cycle out_valid=0, out_ins=NOP, in_ready=1; C never appears.
- Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15, no wrap.
- rst asserted while FULL -> next cycle all outputs at reset values; the first push after deassertion is delivered normally.
